// File: rtl/mem_router_pkg.sv
// ============================================================================
// Package     : mem_router_pkg
// Description : Shared types, constants and region decode for the LSU
//               memory request router and its load-data return mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] c_sentinel0 = 32'hDEAD_BEEF;
  localparam logic [31:0] c_sentinel1 = 32'hBABE_CAFE;

  // Any set bit inside addr[hi:lo] places the access in instruction memory.
  function automatic logic is_imem_region(input logic [31:0] addr, input int lo, input int hi);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i >= lo && i <= hi) hit = hit | addr[i];
    end
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_req_router.sv
// ============================================================================
// Module      : lsu_mem_req_router
// Description : Routes one LSU load/store at a time to IMEM or DMEM and
//               returns a single, registered response with error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_req_router
  import mem_router_pkg::*;
#(
  parameter int          REGION_LO   = 8,
  parameter int          REGION_HI   = 15,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] SENTINEL0   = c_sentinel0,
  parameter logic [31:0] SENTINEL1   = c_sentinel1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_we,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_be,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_rdata,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata
);

  localparam int             CNT_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

  state_e             r_state;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_sel_imem;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic               r_req_ready;

  logic               w_tgt_ready;
  logic               w_tgt_rsp_valid;
  logic [31:0]        w_tgt_rsp_rdata;
  logic               w_sentinel;

  assign w_tgt_ready     = r_sel_imem ? imem_req_ready : dmem_req_ready;
  assign w_tgt_rsp_valid = r_sel_imem ? imem_rsp_valid : dmem_rsp_valid;
  assign w_tgt_rsp_rdata = r_sel_imem ? imem_rsp_rdata : dmem_rsp_rdata;
  assign w_sentinel      = r_sel_imem &&
                           (w_tgt_rsp_rdata == SENTINEL0 || w_tgt_rsp_rdata == SENTINEL1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_sel_imem  <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (lsu_req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= lsu_req_addr;
            r_we        <= lsu_req_we;
            r_wdata     <= lsu_req_wdata;
            r_be        <= lsu_req_be;
            r_sel_imem  <= is_imem_region(lsu_req_addr, REGION_LO, REGION_HI);
            // IMEM is read-only: reject stores without touching any target.
            if (is_imem_region(lsu_req_addr, REGION_LO, REGION_HI) && lsu_req_we) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (w_tgt_ready) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_tgt_rsp_valid) begin
            r_state <= RESP;
            if (r_we) begin
              r_rdata <= '0;
              r_err   <= 1'b0;
            end else if (w_sentinel) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else begin
              r_rdata <= w_tgt_rsp_rdata;
              r_err   <= 1'b0;
            end
          end else if (r_cnt == c_cnt_last) begin
            r_state <= RESP;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_rdata     <= '0;
          r_err       <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_req_ready  = r_req_ready;
  assign lsu_rsp_valid  = (r_state == RESP);
  assign lsu_rsp_rdata  = r_rdata;
  assign lsu_rsp_err    = r_err;

  assign imem_req_valid = (r_state == ISSUE) &&  r_sel_imem;
  assign imem_req_addr  = r_addr;
  assign dmem_req_valid = (r_state == ISSUE) && !r_sel_imem;
  assign dmem_req_addr  = r_addr;
  assign dmem_req_we    = r_we;
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_be    = r_be;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_req_router.sv
// ============================================================================
// Module      : tb_lsu_mem_req_router
// Description : Scoreboard bench for lsu_mem_req_router with a transaction
//               level reference model and randomized target timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_req_router;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr = '0;
  logic        lsu_req_we = 1'b0;
  logic [31:0] lsu_req_wdata = '0;
  logic [3:0]  lsu_req_be = '0;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_rdata = '0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;

  lsu_mem_req_router #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_be(lsu_req_be),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_rdata(imem_rsp_rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level outcome: region, store/load, when the target answers.
  function automatic void model(input logic [31:0] addr, input logic we, input int dr,
                                input int k, input logic [31:0] data,
                                output logic [31:0] rd, output logic er, output int lat);
    bit imem;
    imem = ((addr >> 8) & 32'hFF) != 0;
    if (imem && we) begin
      rd = 0; er = 1; lat = 1;
    end else if (k >= T) begin
      rd = 0; er = 1; lat = 3 + dr + T - 1;
    end else begin
      lat = 3 + dr + k;
      if (we) begin
        rd = 0; er = 0;
      end else if (imem && (data == 32'hDEADBEEF || data == 32'hBABECAFE)) begin
        rd = 0; er = 1;
      end else begin
        rd = data; er = 0;
      end
    end
  endfunction

  // Response monitor: every LSU response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && lsu_rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'(lsu_rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_rdata", lsu_rsp_rdata, e.rdata);
        check("rsp_err", 32'(lsu_rsp_err), 32'(e.err));
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic accept(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, output bit acc, output int c0);
    acc = 0;
    c0  = 0;
    lsu_req_valid = 1; lsu_req_addr = addr; lsu_req_we = we;
    lsu_req_wdata = wdata; lsu_req_be = be;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (lsu_req_ready) begin acc = 1; c0 = cyc; end
    end
    if (!acc) begin
      check("accept_timeout", 32'(lsu_req_ready), 32'h1);
      lsu_req_valid = 0;
    end
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input int dr, input int k,
                        input logic [31:0] data, input bit noise);
    bit imem, acc;
    int c0, lat;
    logic [31:0] rd;
    logic er;
    exp_t e;
    imem = ((addr >> 8) & 32'hFF) != 0;
    accept(addr, we, wdata, be, acc, c0);
    if (!acc) return;
    model(addr, we, dr, k, data, rd, er, lat);
    e.rdata = rd; e.err = er; e.cyc = c0 + lat;
    q.push_back(e);
    @(posedge clk); #1;
    lsu_req_valid = 0; lsu_req_addr = $urandom; lsu_req_we = ~we;
    lsu_req_wdata = $urandom; lsu_req_be = 4'($urandom);
    if (imem && we) begin
      @(negedge clk);
      check("store_imem_no_valid", 32'({imem_req_valid, dmem_req_valid}), 32'h0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= dr; i++) begin
      if (imem) imem_req_ready = (i == dr); else dmem_req_ready = (i == dr);
      if (noise) begin
        imem_rsp_valid = 1'($urandom_range(0, 1)); imem_rsp_rdata = $urandom;
        dmem_rsp_valid = 1'($urandom_range(0, 1)); dmem_rsp_rdata = $urandom;
      end
      @(negedge clk);
      if (imem) begin
        check("imem_valid", 32'({imem_req_valid, dmem_req_valid}), 32'h2);
        check("imem_addr", imem_req_addr, addr);
      end else begin
        check("dmem_valid", 32'({imem_req_valid, dmem_req_valid}), 32'h1);
        check("dmem_fields", {dmem_req_addr[27:0], dmem_req_be}, {addr[27:0], be});
        check("dmem_wdata", dmem_req_wdata, wdata);
        check("dmem_we", 32'(dmem_req_we), 32'(we));
      end
      @(posedge clk); #1;
    end
    imem_req_ready = 0; dmem_req_ready = 0;
    imem_rsp_valid = 0; dmem_rsp_valid = 0;
    for (int w = 0; w < T; w++) begin
      if (noise) begin
        if (imem) begin dmem_rsp_valid = 1'($urandom_range(0, 1)); dmem_rsp_rdata = $urandom; end
        else      begin imem_rsp_valid = 1'($urandom_range(0, 1)); imem_rsp_rdata = $urandom; end
      end
      if (imem) begin imem_rsp_valid = (w == k); imem_rsp_rdata = (w == k) ? data : $urandom; end
      else      begin dmem_rsp_valid = (w == k); dmem_rsp_rdata = (w == k) ? data : $urandom; end
      if (w == 0) begin
        @(negedge clk);
        check("wait_valid_dropped", 32'({imem_req_valid, dmem_req_valid}), 32'h0);
      end
      @(posedge clk); #1;
      if (w == k) break;
    end
    imem_rsp_valid = 0; dmem_rsp_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int c0;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, imem_req_valid, dmem_req_valid}), 32'h0);
    check("reset_rdata", lsu_rsp_rdata, 32'h0);
    rst_n = 1;

    do_txn(32'h0000_0040, 0, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 0);
    do_txn(32'h0000_0100, 0, 32'h0, 4'h0, 3, 0, 32'hCAFE_0001, 0);
    do_txn(32'h0000_0100, 0, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0);
    do_txn(32'h0000_8000, 0, 32'h0, 4'h0, 1, 0, 32'hBABE_CAFE, 0);
    do_txn(32'h0000_0200, 1, 32'h5555_AAAA, 4'hF, 0, 0, 32'h0, 0);
    do_txn(32'h0000_0010, 1, 32'hA5A5_0F0F, 4'h3, 0, T, 32'h0, 0);
    do_txn(32'h0000_0010, 1, 32'hA5A5_0F0F, 4'h3, 0, T - 1, 32'h0, 0);
    do_txn(32'hFFFF_00FF, 0, 32'h0, 4'h0, 2, T - 1, 32'h0BAD_F00D, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom;
        if (((a >> 8) & 32'hFF) == 0) a = a | (32'h100 << $urandom_range(0, 7));
      end else begin
        a = $urandom & 32'hFFFF_00FF;
      end
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, T + 1),
             ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32'hDEAD_BEEF : 32'hBABE_CAFE)
                                          : $urandom,
             1'($urandom_range(0, 1)));
    end

    // Abort a DMEM load with reset while it waits for its response.
    accept(32'h0000_0080, 0, 32'h0, 4'h0, acc, c0);
    if (acc) begin
      @(posedge clk); #1;
      lsu_req_valid = 0;
      dmem_req_ready = 1;
      @(posedge clk); #1;
      dmem_req_ready = 0;
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      check("rst_mid_outputs",
            32'({lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, imem_req_valid, dmem_req_valid}), 32'h0);
      check("rst_mid_addr", dmem_req_addr, 32'h0);
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h7777_7777;
      repeat (2) @(posedge clk);
      #1;
      dmem_rsp_valid = 0;
      rst_n = 1;
    end
    do_txn(32'h0000_0044, 0, 32'h0, 4'h0, 0, 0, 32'h0F0F_1234, 0);

    repeat (5) @(posedge clk);
    check("pending_rsp", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
